// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 mouse init controller.
//   - Command bytes sent to the mouse (CMD_*)
//   - Response bytes expected from the mouse (RSP_*)
//   - Controller state encoding (state_t)
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_ID       = 8'h00;

  typedef enum logic [4:0] {
    START,
    SEND_RST,  TXWAIT_RST,  ACK_RST,
    BAT,       ID,
    SEND_RATE, TXWAIT_RATE, ACK_RATE,
    SEND_VAL,  TXWAIT_VAL,  ACK_VAL,
    SEND_EN,   TXWAIT_EN,   ACK_EN,
    STREAM,
    FAIL
  } state_t;

endpackage

// File: rtl/ps2_timeout_counter.sv
// ps2_timeout_counter: per-state watchdog for the init controller.
// Ports:
//   CLOCK_50 - system clock
//   reset    - synchronous active-high reset
//   clear    - zero the count (asserted on every state change)
//   enable   - count this cycle (controller is waiting for an event)
//   expired  - high while enabled and the count has reached TIMEOUT_CYCLES-1
module ps2_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Saturates at LAST; the controller always leaves the state on expiry,
  // which clears the count.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/ps2_mouse_init_controller.sv
// ps2_mouse_init_controller: drives a PS/2 mouse through power-up init
// (reset, BAT/ID check, set sample rate, enable reporting) and then gates
// received bytes to the packet parser while in stream mode.
// Ports:
//   CLOCK_50, reset                 - clock, synchronous active-high reset
//   ps2_received_data[7:0]          - byte from host core
//   ps2_received_data_en            - 1-cycle strobe, byte valid
//   command_was_sent                - host core finished transmitting
//   error_communication_timed_out   - host core transmit failed
//   the_command[7:0], send_command  - command byte and 1-cycle request
//   parser_data_en                  - received strobe, only in STREAM
//   init_done, init_failed          - in STREAM / reached FAIL (sticky)
//   retry_count[1:0]                - full-sequence restarts consumed
//   fsm_state                       - current controller state (debug)
//
// Handshake: send_command is a single-cycle request with the_command valid
// in that cycle and held afterwards; the host core answers with a
// single-cycle command_was_sent or error_communication_timed_out. Received
// bytes are valid only in the cycle ps2_received_data_en is high; there is
// no back-pressure.
module ps2_mouse_init_controller
  import ps2_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 25_000_000,
  parameter int         MAX_RETRIES    = 3,  // must fit in retry_count
  parameter logic [7:0] SAMPLE_RATE    = 8'd100
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_en,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  output logic [7:0] the_command,
  output logic       send_command,
  output logic       parser_data_en,
  output logic       init_done,
  output logic       init_failed,
  output logic [1:0] retry_count,
  output state_t     fsm_state
);

  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

  state_t     state_q, state_d;
  logic [7:0] cmd_d;
  logic [1:0] retry_d;
  logic       aa_seen_q;
  logic       restart;
  logic       waiting;
  logic       expired;
  logic       rx;

  assign rx = ps2_received_data_en;

  ps2_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (state_d != state_q),
    .enable   (waiting),
    .expired  (expired)
  );

  always_comb begin
    waiting = 1'b0;
    case (state_q)
      TXWAIT_RST, ACK_RST, BAT, ID,
      TXWAIT_RATE, ACK_RATE,
      TXWAIT_VAL, ACK_VAL,
      TXWAIT_EN, ACK_EN: waiting = 1'b1;
      default:           waiting = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      START:     state_d = SEND_RST;
      SEND_RST:  state_d = TXWAIT_RST;
      SEND_RATE: state_d = TXWAIT_RATE;
      SEND_VAL:  state_d = TXWAIT_VAL;
      SEND_EN:   state_d = TXWAIT_EN;

      TXWAIT_RST, TXWAIT_RATE, TXWAIT_VAL, TXWAIT_EN: begin
        if (error_communication_timed_out || expired) begin
          restart = 1'b1;
        end else if (command_was_sent) begin
          // TXWAIT_x is always followed directly by ACK_x in the encoding.
          state_d = state_t'(state_q + 5'd1);
        end
      end

      ACK_RST, ACK_RATE, ACK_VAL, ACK_EN: begin
        if (rx) begin
          if (ps2_received_data == RSP_ACK) begin
            case (state_q)
              ACK_RST:  state_d = BAT;
              ACK_RATE: state_d = SEND_VAL;
              ACK_VAL:  state_d = SEND_EN;
              default:  state_d = STREAM;
            endcase
          end else if (ps2_received_data == RSP_RESEND) begin
            // Resend targets the SEND_x two steps back; no retry consumed.
            state_d = state_t'(state_q - 5'd2);
          end else begin
            restart = 1'b1;
          end
        end else if (expired) begin
          restart = 1'b1;
        end
      end

      BAT: begin
        if (rx) begin
          if (ps2_received_data == RSP_BAT_OK) state_d = ID;
          else                                 restart = 1'b1;
        end else if (expired) begin
          restart = 1'b1;
        end
      end

      ID: begin
        if (rx) begin
          if (ps2_received_data == RSP_ID) state_d = SEND_RATE;
          else                             restart = 1'b1;
        end else if (expired) begin
          restart = 1'b1;
        end
      end

      // A fresh BAT/ID pair in stream mode means the mouse was re-plugged.
      STREAM: begin
        if (rx && aa_seen_q && (ps2_received_data == RSP_ID)) begin
          state_d = SEND_RST;
        end
      end

      default: state_d = state_q;  // FAIL is terminal
    endcase

    retry_d = retry_count;
    if (restart) begin
      if (retry_count < RETRY_LIMIT) begin
        retry_d = retry_count + 2'd1;
        state_d = START;
      end else begin
        state_d = FAIL;
      end
    end

    cmd_d = the_command;
    case (state_d)
      SEND_RST:  cmd_d = CMD_RESET;
      SEND_RATE: cmd_d = CMD_SET_RATE;
      SEND_VAL:  cmd_d = SAMPLE_RATE;
      SEND_EN:   cmd_d = CMD_ENABLE;
      default:   cmd_d = the_command;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= START;
      the_command <= 8'h00;
      retry_count <= 2'd0;
      aa_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      the_command <= cmd_d;
      retry_count <= retry_d;
      if (state_q != STREAM) aa_seen_q <= 1'b0;
      else if (rx)           aa_seen_q <= (ps2_received_data == RSP_BAT_OK);
    end
  end

  assign send_command   = (state_q == SEND_RST) || (state_q == SEND_RATE) ||
                          (state_q == SEND_VAL) || (state_q == SEND_EN);
  assign init_done      = (state_q == STREAM);
  assign init_failed    = (state_q == FAIL);
  assign parser_data_en = init_done && rx;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_ps2_mouse_init_controller.sv
module tb_ps2_mouse_init_controller;
  import ps2_pkg::*;

  localparam int         T  = 1000;
  localparam logic [7:0] SR = 8'd100;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_received_data = 8'h00;
  logic       ps2_received_data_en = 1'b0;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] the_command;
  logic       send_command;
  logic       parser_data_en;
  logic       init_done;
  logic       init_failed;
  logic [1:0] retry_count;
  state_t     fsm_state;

  ps2_mouse_init_controller #(
    .TIMEOUT_CYCLES(T), .MAX_RETRIES(3), .SAMPLE_RATE(SR)
  ) dut (
    .CLOCK_50                      (CLOCK_50),
    .reset                         (reset),
    .ps2_received_data             (ps2_received_data),
    .ps2_received_data_en          (ps2_received_data_en),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .parser_data_en                (parser_data_en),
    .init_done                     (init_done),
    .init_failed                   (init_failed),
    .retry_count                   (retry_count),
    .fsm_state                     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    repeat (90000) @(posedge CLOCK_50);
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard / model state ----------------
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];     // commands the mouse model expects next
  logic [7:0] got_log[$];   // every command observed
  bit         model_stream = 1'b0;
  bit         model_failed = 1'b0;
  bit         failed_known = 1'b1;
  bit         check_en = 1'b0;
  int         last_send_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle compare against the protocol-level model.
  always @(negedge CLOCK_50) begin
    if (check_en) begin
      check("parser_data_en", parser_data_en, ps2_received_data_en & model_stream);
      check("init_done", init_done, model_stream);
      if (failed_known) check("init_failed", init_failed, model_failed);
      if (send_command) begin
        got_log.push_back(the_command);
        last_send_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_send_command", send_command, 0);
        else check("the_command", the_command, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    reset = 1'b1; check_en = 1'b0;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    ps2_received_data_en = 1'b0; command_was_sent = 1'b0;
    model_stream = 1'b0; model_failed = 1'b0; failed_known = 1'b1;
    exp_q.delete();
    check_en = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge CLOCK_50);
    check({tag, "_the_command"}, the_command, 8'h00);
    check({tag, "_send_command"}, send_command, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_init_failed"}, init_failed, 0);
    check({tag, "_retry_count"}, retry_count, 0);
  endtask

  // Expect one command, then play the host core acknowledging its transmit.
  task automatic issue(input logic [7:0] cmd, input int bound);
    int n = 0;
    int d;
    exp_q.push_back(cmd);
    @(negedge CLOCK_50); #1;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge CLOCK_50); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("command_wait_expired", exp_q.size(), 0);
      exp_q.delete();
      return;
    end
    d = $urandom_range(0, 3);
    repeat (d) @(posedge CLOCK_50);
    @(posedge CLOCK_50); #1 command_was_sent = 1'b1;
    @(posedge CLOCK_50); #1 command_was_sent = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    ps2_received_data = b; ps2_received_data_en = 1'b1;
    @(posedge CLOCK_50); #1;
    ps2_received_data_en = 1'b0;
  endtask

  task automatic resp(input logic [7:0] b);
    repeat ($urandom_range(0, 10)) @(posedge CLOCK_50);
    send_byte(b);
  endtask

  task automatic clean_init();
    issue(8'hFF, 200); resp(8'hFA); resp(8'hAA); resp(8'h00);
    issue(8'hF3, 200); resp(8'hFA);
    issue(SR, 200);    resp(8'hFA);
    issue(8'hF4, 200); resp(8'hFA);
    model_stream = 1'b1;
  endtask

  task automatic check_clean_log(input string tag);
    logic [7:0] lit [4];
    lit = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
    check({tag, "_log_len"}, got_log.size(), 4);
    for (int i = 0; i < 4 && i < got_log.size(); i++)
      check({tag, "_log_byte"}, got_log[i], lit[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_cyc;
    int el;
    int n;
    int nlog;
    logic [7:0] b;

    do_reset();
    check_reset_values("reset");

    // Clean init
    got_log.delete();
    clean_init();
    check_clean_log("clean");
    @(negedge CLOCK_50);
    check("clean_init_done", init_done, 1);
    check("clean_retry_count", retry_count, 0);

    // Stream forwarding (0xAA followed by a non-zero byte is not a hot-plug)
    send_byte(8'h09); send_byte(8'h05); send_byte(8'hFB);
    for (int i = 0; i < 24; i++) begin
      b = (i % 6 == 0) ? 8'hAA : 8'($urandom_range(1, 255));
      send_byte(b);
    end
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00);

    // Hot-plug BAT in stream
    send_byte(8'hAA); send_byte(8'h00);
    model_stream = 1'b0;
    got_log.delete();
    clean_init();
    check_clean_log("hotplug");
    @(negedge CLOCK_50);
    check("hotplug_retry_count", retry_count, 0);

    // Resend of 0xF3
    do_reset();
    got_log.delete();
    issue(8'hFF, 200); resp(8'hFA); resp(8'hAA); resp(8'h00);
    issue(8'hF3, 200); resp(8'hFE);
    issue(8'hF3, 200); resp(8'hFA);
    issue(SR, 200);    resp(8'hFA);
    issue(8'hF4, 200); resp(8'hFA);
    model_stream = 1'b1;
    @(negedge CLOCK_50);
    check("resend_log_len", got_log.size(), 5);
    check("resend_retry_count", retry_count, 0);
    check("resend_init_done", init_done, 1);

    // Bad BAT, then a random wrong ID byte
    do_reset();
    issue(8'hFF, 200); resp(8'hFA); resp(8'hFC);
    clean_init();
    @(negedge CLOCK_50);
    check("bad_bat_retry_count", retry_count, 1);
    send_byte(8'hAA); send_byte(8'h00);
    model_stream = 1'b0;
    issue(8'hFF, 200); resp(8'hFA); resp(8'hAA); resp(8'($urandom_range(1, 255)));
    clean_init();
    @(negedge CLOCK_50);
    check("bad_id_retry_count", retry_count, 2);

    // Reset while waiting for the sample-rate ACK
    send_byte(8'hAA); send_byte(8'h00);
    model_stream = 1'b0;
    issue(8'hFF, 200); resp(8'hFA); resp(8'hAA); resp(8'h00);
    issue(8'hF3, 200); resp(8'hFA);
    issue(SR, 200);
    repeat (3) @(posedge CLOCK_50);
    do_reset();
    check_reset_values("mid_reset");
    got_log.delete();
    clean_init();
    check_clean_log("after_reset");

    // Timeouts exhaust the retries
    do_reset();
    failed_known = 1'b0;
    issue(8'hFF, 200);
    first_cyc = last_send_cyc;
    for (int i = 0; i < 3; i++) issue(8'hFF, 2000);
    n = 0;
    @(negedge CLOCK_50);
    while (!init_failed && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    el = cyc - first_cyc;
    check("fail_latency_in_window", (el >= 4 * T) && (el <= 4 * T + 60), 1);
    check("timeout_retry_count", retry_count, 3);
    check("timeout_init_failed", init_failed, 1);
    model_failed = 1'b1;
    failed_known = 1'b1;
    nlog = got_log.size();
    repeat (300) @(posedge CLOCK_50);
    check("no_send_after_fail", got_log.size(), nlog);
    do_reset();
    check_reset_values("after_fail");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
